// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : VGA raster timing generator. Produces the horizontal/vertical
//            pixel position, sync pulses, visible-area flag and per-line /
//            per-frame strobes feeding the drawing pipeline.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   vga_pix_clk     in   1   single clock, all state updates on rising edge
//   rst             in   1   asynchronous reset, active low
//   pix_en          in   1   pixel advance enable (tie 1 for a true pixel clk)
//   sx              out  H   current pixel column
//   sy              out  V   current pixel line
//   display_enabled out  1   current pixel lies in the visible area
//   hsync           out  1   horizontal sync, active level H_SYNC_POL
//   vsync           out  1   vertical sync, active level V_SYNC_POL
//   line_stb        out  1   one-clock pulse when sx becomes 0
//   frame_stb       out  1   one-clock pulse when (sx,sy) becomes (0,0)
//   frame_cnt       out  16  number of frame starts since reset, wrapping
// ============================================================================
module vga_timing_gen #(
    parameter int H_VISIBLE_AREA = 640,
    parameter int H_FRONT_PORCH  = 16,
    parameter int H_SYNC_PULSE   = 96,
    parameter int H_BACK_PORCH   = 48,
    parameter int V_VISIBLE_AREA = 480,
    parameter int V_FRONT_PORCH  = 10,
    parameter int V_SYNC_PULSE   = 2,
    parameter int V_BACK_PORCH   = 33,
    parameter bit H_SYNC_POL     = 1'b0,
    parameter bit V_SYNC_POL     = 1'b0,
    localparam int H_WHOLE_LINE  = H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH,
    localparam int V_WHOLE_LINE  = V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH,
    localparam int H_ADDR_WIDTH  = $clog2(H_WHOLE_LINE),
    localparam int V_ADDR_WIDTH  = $clog2(V_WHOLE_LINE)
) (
    input  logic                    vga_pix_clk,
    input  logic                    rst,
    input  logic                    pix_en,
    output logic [H_ADDR_WIDTH-1:0] sx,
    output logic [V_ADDR_WIDTH-1:0] sy,
    output logic                    display_enabled,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    line_stb,
    output logic                    frame_stb,
    output logic [15:0]             frame_cnt
);

    // ------------------------------------------------------------------------
    // Counter limits and decode boundaries. The boundaries are one bit wider
    // than the counters because the end of the sync zone may equal the whole
    // line length (zero back porch), which would not fit in the counter width.
    // ------------------------------------------------------------------------
    localparam logic [H_ADDR_WIDTH-1:0] c_H_LAST       = H_ADDR_WIDTH'(H_WHOLE_LINE - 1);
    localparam logic [V_ADDR_WIDTH-1:0] c_V_LAST       = V_ADDR_WIDTH'(V_WHOLE_LINE - 1);

    localparam logic [H_ADDR_WIDTH:0]   c_H_VIS_END    = (H_ADDR_WIDTH + 1)'(H_VISIBLE_AREA);
    localparam logic [H_ADDR_WIDTH:0]   c_H_SYNC_START = (H_ADDR_WIDTH + 1)'(H_VISIBLE_AREA + H_FRONT_PORCH);
    localparam logic [H_ADDR_WIDTH:0]   c_H_SYNC_END   = (H_ADDR_WIDTH + 1)'(H_VISIBLE_AREA + H_FRONT_PORCH
                                                                             + H_SYNC_PULSE);

    localparam logic [V_ADDR_WIDTH:0]   c_V_VIS_END    = (V_ADDR_WIDTH + 1)'(V_VISIBLE_AREA);
    localparam logic [V_ADDR_WIDTH:0]   c_V_SYNC_START = (V_ADDR_WIDTH + 1)'(V_VISIBLE_AREA + V_FRONT_PORCH);
    localparam logic [V_ADDR_WIDTH:0]   c_V_SYNC_END   = (V_ADDR_WIDTH + 1)'(V_VISIBLE_AREA + V_FRONT_PORCH
                                                                             + V_SYNC_PULSE);

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    logic [H_ADDR_WIDTH-1:0] r_sx;
    logic [V_ADDR_WIDTH-1:0] r_sy;
    logic                    r_display_enabled;
    logic                    r_hsync;
    logic                    r_vsync;
    logic                    r_line_stb;
    logic                    r_frame_stb;
    logic [15:0]             r_frame_cnt;

    // ------------------------------------------------------------------------
    // Next-position computation
    // ------------------------------------------------------------------------
    logic                    w_line_end;
    logic                    w_frame_end;
    logic [H_ADDR_WIDTH-1:0] w_sx_next;
    logic [V_ADDR_WIDTH-1:0] w_sy_next;

    always_comb begin
        w_line_end  = (r_sx == c_H_LAST);
        w_frame_end = w_line_end && (r_sy == c_V_LAST);

        if (w_line_end) begin
            w_sx_next = '0;
        end else begin
            w_sx_next = r_sx + 1'b1;
        end

        // The line counter only moves when the column wraps.
        if (w_frame_end) begin
            w_sy_next = '0;
        end else if (w_line_end) begin
            w_sy_next = r_sy + 1'b1;
        end else begin
            w_sy_next = r_sy;
        end
    end

    // ------------------------------------------------------------------------
    // Output decode on the *next* position, so that once registered every
    // output describes the pixel that sx/sy show in the same cycle.
    // ------------------------------------------------------------------------
    logic [H_ADDR_WIDTH:0] w_sx_next_ext;
    logic [V_ADDR_WIDTH:0] w_sy_next_ext;
    logic                  w_h_visible;
    logic                  w_v_visible;
    logic                  w_h_sync_zone;
    logic                  w_v_sync_zone;
    logic                  w_display_enabled_next;
    logic                  w_hsync_next;
    logic                  w_vsync_next;

    always_comb begin
        w_sx_next_ext = {1'b0, w_sx_next};
        w_sy_next_ext = {1'b0, w_sy_next};

        w_h_visible   = (w_sx_next_ext < c_H_VIS_END);
        w_v_visible   = (w_sy_next_ext < c_V_VIS_END);

        w_h_sync_zone = (w_sx_next_ext >= c_H_SYNC_START) && (w_sx_next_ext < c_H_SYNC_END);
        w_v_sync_zone = (w_sy_next_ext >= c_V_SYNC_START) && (w_sy_next_ext < c_V_SYNC_END);

        w_display_enabled_next = w_h_visible && w_v_visible;
        w_hsync_next           = w_h_sync_zone ? H_SYNC_POL : ~H_SYNC_POL;
        w_vsync_next           = w_v_sync_zone ? V_SYNC_POL : ~V_SYNC_POL;
    end

    // ------------------------------------------------------------------------
    // Registers. The position resets to the last pixel of the frame so that
    // the very first enabled edge wraps to (0,0) and raises frame_stb like any
    // other frame start.
    // ------------------------------------------------------------------------
    always_ff @(posedge vga_pix_clk or negedge rst) begin
        if (!rst) begin
            r_sx              <= c_H_LAST;
            r_sy              <= c_V_LAST;
            r_display_enabled <= 1'b0;
            r_hsync           <= ~H_SYNC_POL;
            r_vsync           <= ~V_SYNC_POL;
            r_line_stb        <= 1'b0;
            r_frame_stb       <= 1'b0;
            r_frame_cnt       <= 16'd0;
        end else begin
            // Strobes default low every clock so they can never stretch,
            // regardless of how sparse pix_en is.
            r_line_stb  <= 1'b0;
            r_frame_stb <= 1'b0;

            if (pix_en) begin
                r_sx              <= w_sx_next;
                r_sy              <= w_sy_next;
                r_display_enabled <= w_display_enabled_next;
                r_hsync           <= w_hsync_next;
                r_vsync           <= w_vsync_next;
                r_line_stb        <= w_line_end;
                r_frame_stb       <= w_frame_end;
                if (w_frame_end) begin
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs are driven straight from registers: no input-to-output path.
    // ------------------------------------------------------------------------
    assign sx              = r_sx;
    assign sy              = r_sy;
    assign display_enabled = r_display_enabled;
    assign hsync           = r_hsync;
    assign vsync           = r_vsync;
    assign line_stb        = r_line_stb;
    assign frame_stb       = r_frame_stb;
    assign frame_cnt       = r_frame_cnt;

endmodule
`default_nettype wire
